// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU: one operation in flight,
// operands registered on accept, result held until the owning requester takes it.
module alu_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [4:0]  req0_shamt,
   input  logic [3:0]  req0_ctrl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [4:0]  req1_shamt,
   input  logic [3:0]  req1_ctrl,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_result,
   output logic        resp0_zero,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_result,
   output logic        resp1_zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_shamt,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state;
   logic        owner;
   logic        last_gnt;
   logic        sel;
   logic        accept;
   logic        resp_ack;
   logic [31:0] op_a_p0;
   logic [31:0] op_b_p0;
   logic [4:0]  op_shamt_p0;
   logic [3:0]  op_ctrl_p0;
   logic [31:0] res_p1;
   logic        zero_p1;

   // On a tie, round-robin favours whoever was not granted last
   always_comb begin
      sel = 1'b0;
      if (req0_valid && req1_valid)
         sel = FIXED_PRIO ? 1'b0 : ~last_gnt;
      else if (req1_valid)
         sel = 1'b1;
   end

   assign accept     = (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && !sel;
   assign req1_ready = accept && sel;
   assign resp_ack   = owner ? resp1_ready : resp0_ready;

   assign resp0_valid  = (state == RESP) && !owner;
   assign resp1_valid  = (state == RESP) && owner;
   assign resp0_result = res_p1;
   assign resp1_result = res_p1;
   assign resp0_zero   = zero_p1;
   assign resp1_zero   = zero_p1;
   assign busy         = (state != IDLE);

   assign alu_a     = op_a_p0;
   assign alu_b     = op_b_p0;
   assign alu_shamt = op_shamt_p0;
   assign alu_ctrl  = op_ctrl_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_gnt    <= 1'b1;
         op_a_p0     <= '0;
         op_b_p0     <= '0;
         op_shamt_p0 <= '0;
         op_ctrl_p0  <= '0;
         res_p1      <= '0;
         zero_p1     <= 1'b0;
      end else begin
         case (state)
            // Accept stage: operands into p0 registers
            IDLE: begin
               if (accept) begin
                  owner       <= sel;
                  last_gnt    <= sel;
                  op_a_p0     <= sel ? req1_a     : req0_a;
                  op_b_p0     <= sel ? req1_b     : req0_b;
                  op_shamt_p0 <= sel ? req1_shamt : req0_shamt;
                  op_ctrl_p0  <= sel ? req1_ctrl  : req0_ctrl;
                  state       <= EXEC;
               end
            end
            // Execute stage: ALU output into p1 registers
            EXEC: begin
               res_p1  <= alu_result;
               zero_p1 <= alu_zero;
               state   <= RESP;
            end
            RESP: begin
               if (resp_ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
